// File: rtl/usb_mouse_ps2_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : usb_mouse_ps2_sched_if
// Purpose  : Bundles the synchronized dock-mouse datapath inputs and the
//            PS/2 mouse event outputs of the packet scheduler.
// Ports    : enable, is_mouse, report_cnt[15:0], buttons[7:0], dx[15:0],
//            dy[15:0]                       (master -> slave)
//            ps2_mouse[24:0], pkt_strobe, sat_flag (slave -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface usb_mouse_ps2_sched_if;
  logic        enable;
  logic        is_mouse;
  logic [15:0] report_cnt;
  logic [7:0]  buttons;
  logic [15:0] dx;
  logic [15:0] dy;
  logic [24:0] ps2_mouse;
  logic        pkt_strobe;
  logic        sat_flag;

  modport master (
    output enable, is_mouse, report_cnt, buttons, dx, dy,
    input  ps2_mouse, pkt_strobe, sat_flag
  );

  modport slave (
    input  enable, is_mouse, report_cnt, buttons, dx, dy,
    output ps2_mouse, pkt_strobe, sat_flag
  );
endinterface
`default_nettype wire

// File: rtl/usb_mouse_ps2_sched.sv
`default_nettype none
// ============================================================================
// Module   : usb_mouse_ps2_sched
// Purpose  : Turns synchronized USB mouse reports into a rate-limited PS/2
//            mouse event stream. New reports are detected by a change of the
//            report counter; their deltas are accumulated (saturating) and
//            drained into packets of at most +255/-256 per axis, no more often
//            than once every PKT_INTERVAL clock cycles.
// Ports    : clk      - system clock
//            reset_n  - asynchronous active-low reset
//            bus      - slave side of usb_mouse_ps2_sched_if (inputs enable,
//                       is_mouse, report_cnt, buttons, dx, dy; outputs
//                       ps2_mouse, pkt_strobe, sat_flag)
// Revision : 1.0 - initial release
// ============================================================================
module usb_mouse_ps2_sched #(
  parameter logic [15:0] PKT_INTERVAL = 16'd800,
  parameter int          ACC_W        = 12,
  parameter bit          INVERT_Y     = 1'b1
) (
  input wire logic              clk,
  input wire logic              reset_n,
  usb_mouse_ps2_sched_if.slave  bus
);

  // Sum width covers acc - e + delta without wrap for any legal ACC_W.
  localparam int C_SUM_W = ((ACC_W > 16) ? ACC_W : 16) + 2;
  localparam logic signed [ACC_W-1:0]   C_ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0]   C_ACC_MIN  = -C_ACC_MAX;
  localparam logic signed [C_SUM_W-1:0] C_SUM_MAX  = C_SUM_W'(C_ACC_MAX);
  localparam logic signed [C_SUM_W-1:0] C_SUM_MIN  = C_SUM_W'(C_ACC_MIN);
  localparam logic signed [ACC_W-1:0]   C_CLAMP_HI = ACC_W'(255);
  localparam logic signed [ACC_W-1:0]   C_CLAMP_LO = ACC_W'(-256);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    EMIT  = 2'd2
  } state_t;

  state_t                    r_state, w_state_next;
  logic signed [ACC_W-1:0]   r_acc_x, r_acc_y;
  logic [15:0]               r_last_cnt;
  logic                      r_primed;
  logic [15:0]               r_ivl_cnt;
  logic [2:0]                r_btn_cur, r_btn_sent;
  logic [24:0]               r_ps2;
  logic                      r_strobe;
  logic                      r_sat;

  logic                      w_active, w_run, w_new_report, w_pending;
  logic                      w_ivl_done, w_emit;
  logic signed [ACC_W-1:0]   w_ex, w_ey;
  logic                      w_ovf_x, w_ovf_y;
  logic signed [C_SUM_W-1:0] w_dx_ext, w_dy_ext, w_sum_x, w_sum_y;
  logic signed [ACC_W-1:0]   w_acc_x_next, w_acc_y_next;
  logic                      w_sat_any;
  logic [24:0]               w_packet;

  // Only the three standard buttons are forwarded.
  wire logic w_unused_buttons = &{1'b0, bus.buttons[7:3]};

  assign w_active     = bus.is_mouse && bus.enable;
  assign w_run        = w_active && (r_state != IDLE);
  assign w_new_report = w_run && r_primed && (bus.report_cnt != r_last_cnt);
  assign w_pending    = (r_acc_x != '0) || (r_acc_y != '0) || (r_btn_cur != r_btn_sent);
  assign w_ivl_done   = (r_ivl_cnt >= PKT_INTERVAL - 16'd1);
  assign w_emit       = w_active && (r_state == EMIT);

  // Next-state logic; losing mouse/enable always drops back to IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    w_state_next = ARMED;
      ARMED:   if (w_pending && w_ivl_done) w_state_next = EMIT;
      EMIT:    w_state_next = ARMED;
      default: w_state_next = IDLE;
    endcase
    if (!w_active) w_state_next = IDLE;
  end

  // Clamp to the PS/2 9-bit signed range and flag overflow per axis.
  always_comb begin
    w_ex    = r_acc_x;
    w_ey    = r_acc_y;
    w_ovf_x = 1'b0;
    w_ovf_y = 1'b0;
    if (r_acc_x > C_CLAMP_HI) begin
      w_ex = C_CLAMP_HI; w_ovf_x = 1'b1;
    end else if (r_acc_x < C_CLAMP_LO) begin
      w_ex = C_CLAMP_LO; w_ovf_x = 1'b1;
    end
    if (r_acc_y > C_CLAMP_HI) begin
      w_ey = C_CLAMP_HI; w_ovf_y = 1'b1;
    end else if (r_acc_y < C_CLAMP_LO) begin
      w_ey = C_CLAMP_LO; w_ovf_y = 1'b1;
    end
  end

  assign w_packet = {~r_ps2[24], w_ey[7:0], w_ex[7:0],
                     w_ovf_y, w_ovf_x, w_ey[ACC_W-1], w_ex[ACC_W-1],
                     1'b1, r_btn_cur};

  // Accumulator update: drain the emitted part, add the new delta, then
  // saturate, so a report landing in the EMIT cycle is never lost.
  always_comb begin
    w_dx_ext = C_SUM_W'(signed'(bus.dx));
    w_dy_ext = C_SUM_W'(signed'(bus.dy));
    if (INVERT_Y) w_dy_ext = -w_dy_ext;

    w_sum_x = C_SUM_W'(r_acc_x);
    w_sum_y = C_SUM_W'(r_acc_y);
    if (w_emit) begin
      w_sum_x = w_sum_x - C_SUM_W'(w_ex);
      w_sum_y = w_sum_y - C_SUM_W'(w_ey);
    end
    if (w_new_report) begin
      w_sum_x = w_sum_x + w_dx_ext;
      w_sum_y = w_sum_y + w_dy_ext;
    end

    w_sat_any    = 1'b0;
    w_acc_x_next = w_sum_x[ACC_W-1:0];
    w_acc_y_next = w_sum_y[ACC_W-1:0];
    if (w_sum_x > C_SUM_MAX) begin
      w_acc_x_next = C_ACC_MAX; w_sat_any = 1'b1;
    end else if (w_sum_x < C_SUM_MIN) begin
      w_acc_x_next = C_ACC_MIN; w_sat_any = 1'b1;
    end
    if (w_sum_y > C_SUM_MAX) begin
      w_acc_y_next = C_ACC_MAX; w_sat_any = 1'b1;
    end else if (w_sum_y < C_SUM_MIN) begin
      w_acc_y_next = C_ACC_MIN; w_sat_any = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_acc_x    <= '0;
      r_acc_y    <= '0;
      r_last_cnt <= '0;
      r_primed   <= 1'b0;
      r_ivl_cnt  <= '0;
      r_btn_cur  <= '0;
      r_btn_sent <= '0;
      r_ps2      <= '0;
      r_strobe   <= 1'b0;
      r_sat      <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_strobe <= 1'b0;
      if (!w_active) begin
        r_acc_x    <= '0;
        r_acc_y    <= '0;
        r_btn_cur  <= '0;
        r_btn_sent <= '0;
        r_primed   <= 1'b0;
        r_ivl_cnt  <= '0;
      end else if (r_state == IDLE) begin
        // Prime on the current counter value so the report already on the
        // bus is not treated as new.
        r_last_cnt <= bus.report_cnt;
        r_primed   <= 1'b1;
        r_ivl_cnt  <= '0;
      end else begin
        r_acc_x <= w_acc_x_next;
        r_acc_y <= w_acc_y_next;
        if (w_new_report) begin
          r_last_cnt <= bus.report_cnt;
          r_btn_cur  <= bus.buttons[2:0];
        end
        // Cleared on entry to EMIT so EMIT counts as cycle 0 of the next
        // interval; that makes consecutive packets PKT_INTERVAL apart.
        if ((r_state == ARMED) && (w_state_next == EMIT))
          r_ivl_cnt <= '0;
        else if (r_ivl_cnt < PKT_INTERVAL - 16'd1)
          r_ivl_cnt <= r_ivl_cnt + 16'd1;
        if (w_emit) begin
          r_ps2      <= w_packet;
          r_strobe   <= 1'b1;
          r_btn_sent <= r_btn_cur;
        end
        if (w_sat_any)
          r_sat <= 1'b1;
        else if (w_emit)
          r_sat <= 1'b0;
      end
    end
  end

  assign bus.ps2_mouse  = r_ps2;
  assign bus.pkt_strobe = r_strobe;
  assign bus.sat_flag   = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_usb_mouse_ps2_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_mouse_ps2_sched
// Purpose  : Directed self-checking bench for usb_mouse_ps2_sched with a
//            short packet interval (16 cycles), ACC_W=12, INVERT_Y=1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb_mouse_ps2_sched;
  localparam int P = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  usb_mouse_ps2_sched_if bus();

  usb_mouse_ps2_sched #(
    .PKT_INTERVAL(16'(P)),
    .ACC_W(12),
    .INVERT_Y(1'b1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic exp_tog  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] c, input logic [15:0] x,
                      input logic [15:0] y, input logic [7:0] b);
    bus.report_cnt = c;
    bus.dx         = x;
    bus.dy         = y;
    bus.buttons    = b;
    tick();
  endtask

  // Waits up to 'limit' cycles for a strobe; reports whether and when.
  task automatic wait_strobe(input int limit, output bit seen, output int at);
    seen = 1'b0;
    at   = 0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (bus.pkt_strobe === 1'b1) begin
        seen = 1'b1;
        at   = cyc;
        return;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (bus.ps2_mouse !== 25'h0) begin
      n_fail++; $display("FAIL reset_ps2: got %h, expected %h", bus.ps2_mouse, 25'h0);
    end
    n_checks++;
    if (bus.pkt_strobe !== 1'b0 || bus.sat_flag !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: got strobe=%b sat=%b, expected 0 0", bus.pkt_strobe, bus.sat_flag);
    end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single_move();
    bit seen; int at;
    repeat (P + 2) tick();
    send(16'd1, 16'd5, 16'd3, 8'h00);
    wait_strobe(8, seen, at);
    n_checks++;
    if (!seen) begin
      n_fail++; $display("FAIL single_strobe: got no strobe, expected one within 8 cycles");
    end else begin
      exp_tog = ~exp_tog;
      n_checks++;
      if (bus.ps2_mouse !== {exp_tog, 24'hFD0528}) begin
        n_fail++; $display("FAIL single_pkt: got %h, expected %h", bus.ps2_mouse, {exp_tog, 24'hFD0528});
      end
    end
    tick();
    n_checks++;
    if (bus.pkt_strobe !== 1'b0) begin
      n_fail++; $display("FAIL single_pulse_width: got strobe=%b, expected 0", bus.pkt_strobe);
    end
  endtask

  task automatic test_large_split();
    bit seen; int at; int prev;
    logic [23:0] exp_pkt [3] = '{24'h00FF48, 24'h00FF48, 24'h005A08};
    repeat (P + 2) tick();
    send(16'd2, 16'd600, 16'd0, 8'h00);
    prev = 0;
    for (int k = 0; k < 3; k++) begin
      wait_strobe(2 * P, seen, at);
      n_checks++;
      if (!seen) begin
        n_fail++; $display("FAIL split_strobe%0d: got no strobe, expected one", k);
      end else begin
        exp_tog = ~exp_tog;
        n_checks++;
        if (bus.ps2_mouse !== {exp_tog, exp_pkt[k]}) begin
          n_fail++; $display("FAIL split_pkt%0d: got %h, expected %h", k, bus.ps2_mouse, {exp_tog, exp_pkt[k]});
        end
        if (k > 0) begin
          n_checks++;
          if ((at - prev) != P) begin
            n_fail++; $display("FAIL split_spacing%0d: got %0d cycles, expected %0d", k, at - prev, P);
          end
        end
        prev = at;
      end
    end
    wait_strobe(3 * P, seen, at);
    n_checks++;
    if (seen) begin
      n_fail++; $display("FAIL split_extra: got strobe at cycle %0d, expected none", at);
    end
  endtask

  task automatic test_buttons();
    bit seen; int at;
    send(16'd3, 16'd0, 16'd0, 8'h01);
    wait_strobe(8, seen, at);
    n_checks++;
    if (!seen) begin
      n_fail++; $display("FAIL btn_press_strobe: got no strobe, expected one");
    end else begin
      exp_tog = ~exp_tog;
      n_checks++;
      if (bus.ps2_mouse !== {exp_tog, 24'h000009}) begin
        n_fail++; $display("FAIL btn_press_pkt: got %h, expected %h", bus.ps2_mouse, {exp_tog, 24'h000009});
      end
    end
    send(16'd4, 16'd0, 16'd0, 8'h00);
    wait_strobe(2 * P, seen, at);
    n_checks++;
    if (!seen) begin
      n_fail++; $display("FAIL btn_release_strobe: got no strobe, expected one");
    end else begin
      exp_tog = ~exp_tog;
      n_checks++;
      if (bus.ps2_mouse !== {exp_tog, 24'h000008}) begin
        n_fail++; $display("FAIL btn_release_pkt: got %h, expected %h", bus.ps2_mouse, {exp_tog, 24'h000008});
      end
    end
    wait_strobe(3 * P, seen, at);
    n_checks++;
    if (seen) begin
      n_fail++; $display("FAIL btn_extra: got strobe at cycle %0d, expected none", at);
    end
  endtask

  task automatic test_wrap_jump();
    bit seen; int at;
    send(16'hFFFF, 16'd0, 16'd0, 8'h00);
    send(16'h0000, 16'd1, 16'd0, 8'h00);
    send(16'h0005, 16'd2, 16'd0, 8'h00);
    wait_strobe(8, seen, at);
    n_checks++;
    if (!seen) begin
      n_fail++; $display("FAIL wrap_strobe: got no strobe, expected one");
    end else begin
      exp_tog = ~exp_tog;
      n_checks++;
      if (bus.ps2_mouse !== {exp_tog, 24'h000308}) begin
        n_fail++; $display("FAIL wrap_pkt: got %h, expected %h", bus.ps2_mouse, {exp_tog, 24'h000308});
      end
    end
  endtask

  task automatic test_saturation();
    bit seen; int at;
    for (int k = 0; k < 10; k++) send(16'(6 + k), 16'd1000, 16'd0, 8'h00);
    n_checks++;
    if (bus.sat_flag !== 1'b1) begin
      n_fail++; $display("FAIL sat_set: got sat_flag=%b, expected 1", bus.sat_flag);
    end
    n_checks++;
    if (bus.pkt_strobe !== 1'b0) begin
      n_fail++; $display("FAIL sat_early_pkt: got strobe=%b within interval, expected 0", bus.pkt_strobe);
    end
    wait_strobe(2 * P, seen, at);
    n_checks++;
    if (!seen) begin
      n_fail++; $display("FAIL sat_strobe: got no strobe, expected one");
    end else begin
      exp_tog = ~exp_tog;
      n_checks++;
      if (bus.ps2_mouse !== {exp_tog, 24'h00FF48}) begin
        n_fail++; $display("FAIL sat_pkt: got %h, expected %h", bus.ps2_mouse, {exp_tog, 24'h00FF48});
      end
      n_checks++;
      if (bus.sat_flag !== 1'b0) begin
        n_fail++; $display("FAIL sat_clear: got sat_flag=%b, expected 0", bus.sat_flag);
      end
    end
  endtask

  task automatic test_disable();
    bit seen; int at;
    logic [24:0] saved;
    bus.enable = 1'b0;
    tick();
    tick();
    saved = bus.ps2_mouse;
    bus.enable = 1'b1;
    tick();
    send(16'd16, 16'd40, 16'd0, 8'h00);
    tick();
    bus.enable = 1'b0;
    wait_strobe(3 * P, seen, at);
    n_checks++;
    if (seen) begin
      n_fail++; $display("FAIL disable_strobe: got strobe at cycle %0d, expected none", at);
    end
    n_checks++;
    if (bus.ps2_mouse !== saved) begin
      n_fail++; $display("FAIL disable_hold: got %h, expected %h", bus.ps2_mouse, saved);
    end
    bus.report_cnt = 16'd17;
    bus.dx         = 16'd7;
    bus.enable     = 1'b1;
    tick();
    wait_strobe(3 * P, seen, at);
    n_checks++;
    if (seen) begin
      n_fail++; $display("FAIL reprime_strobe: got strobe at cycle %0d, expected none", at);
    end
  endtask

  task automatic test_reset_mid();
    bit seen; int at;
    send(16'd18, 16'd32767, 16'd0, 8'h00);
    tick();
    n_checks++;
    if (bus.sat_flag !== 1'b1) begin
      n_fail++; $display("FAIL midrst_pre_sat: got sat_flag=%b, expected 1", bus.sat_flag);
    end
    #3;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (bus.ps2_mouse !== 25'h0) begin
      n_fail++; $display("FAIL midrst_ps2: got %h, expected %h", bus.ps2_mouse, 25'h0);
    end
    n_checks++;
    if (bus.sat_flag !== 1'b0 || bus.pkt_strobe !== 1'b0) begin
      n_fail++; $display("FAIL midrst_flags: got sat=%b strobe=%b, expected 0 0", bus.sat_flag, bus.pkt_strobe);
    end
    tick();
    reset_n = 1'b1;
    exp_tog = 1'b0;
    wait_strobe(3 * P, seen, at);
    n_checks++;
    if (seen) begin
      n_fail++; $display("FAIL midrst_reprime: got strobe at cycle %0d, expected none", at);
    end
    n_checks++;
    if (bus.ps2_mouse !== 25'h0) begin
      n_fail++; $display("FAIL midrst_ps2_after: got %h, expected %h", bus.ps2_mouse, 25'h0);
    end
  endtask

  initial begin
    bus.enable     = 1'b1;
    bus.is_mouse   = 1'b1;
    bus.report_cnt = 16'd0;
    bus.buttons    = 8'h00;
    bus.dx         = 16'd0;
    bus.dy         = 16'd0;
    test_reset();
    test_single_move();
    test_large_split();
    test_buttons();
    test_wrap_jump();
    test_saturation();
    test_disable();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/usb_mouse_ps2_sched.md
Name: usb_mouse_ps2_sched

Overview:
- Sequences the synchronized dock-mouse datapath into a rate-limited PS/2 mouse packet stream.
- Detects each new USB report by comparing the report counter against the last one seen. Accumulates the report's deltas and tracks button state.
- Emits a 25-bit PS/2 event word, toggling bit 24, no faster than a programmable packet interval. Any residual motion is carried into later packets.
- Sits between the mouse synchronizer stage and the core's PS/2 mouse consumer.

Parameters:
- PKT_INTERVAL, 16'd800, minimum clk cycles between two emitted packets (≥2).
- ACC_W, 12, width of the signed X/Y motion accumulators (≥10).
- INVERT_Y, 1, 1 = negate Y (USB down-positive to PS/2 up-positive).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  scheduler enable; 0 = freeze, no packets, accumulators cleared
- is_mouse  in  1  input type is mouse (synchronized)
- report_cnt  in  16  report counter, byte-swapped to normal order, synchronized
- buttons  in  8  bit0 left, bit1 right, bit2 middle
- dx  in  16  signed X delta of current report
- dy  in  16  signed Y delta of current report
- ps2_mouse  out  25  [24] toggle, [23:16] Y low byte, [15:8] X low byte, [7:0] status
- pkt_strobe  out  1  one-cycle pulse in the cycle ps2_mouse updates
- sat_flag  out  1  sticky: an accumulator saturated since the last packet

Behaviour:
- Reset (async, reset_n=0):
  - ps2_mouse=25'h0, pkt_strobe=0, sat_flag=0.
  - Accumulators=0, last_cnt=0, primed=0, interval counter=0.
  - State=IDLE.
- States: IDLE, ARMED, EMIT.
- IDLE: when is_mouse && enable, the next cycle loads last_cnt=report_cnt and sets primed=1, with no accumulation. Goes to ARMED.
- ARMED:
  - A new report is report_cnt != last_cnt. On a new report, last_cnt is updated, acc_x+=dx, acc_y+=(INVERT_Y ? -dy : dy), and btn_cur=buttons[2:0].
  - Accumulation saturates at ±(2^(ACC_W-1)-1); sat_flag is set on saturation.
  - Counter wrap (FFFF→0000) and jumps >1 count as one new report.
- Pending = acc_x≠0 or acc_y≠0 or btn_cur≠btn_sent.
- Transition to EMIT when pending and the interval counter ≥ PKT_INTERVAL-1.
- EMIT (1 cycle):
  - ex=clamp(acc_x,-256,255), ey=clamp(acc_y,-256,255).
  - ps2_mouse[23:16]=ey[7:0], [15:8]=ex[7:0].
  - [7]=Y overflow (acc_y outside clamp range), [6]=X overflow, [5]=ey sign, [4]=ex sign, [3]=1, [2:0]={middle,right,left}.
  - ps2_mouse[24] toggles; pkt_strobe=1.
  - acc-=e for each axis (residue retained); btn_sent=btn_cur; interval counter=0; sat_flag cleared.
  - Returns to ARMED.
- Interval counter increments every cycle in ARMED and saturates at PKT_INTERVAL-1.
- Packet spacing:
  - A packet becomes pending after the interval has expired: emitted in the cycle after the report is seen.
  - Back-to-back packets are exactly PKT_INTERVAL cycles apart.
- Simultaneous new report and EMIT cycle: acc_next = acc - e + delta, with saturation applied after the sum. btn_cur takes the new buttons, btn_sent the pre-update btn_cur, so the change stays pending.
- is_mouse falls or enable=0:
  - Any state goes to IDLE next cycle; accumulators and btn_cur/btn_sent are cleared; primed=0.
  - ps2_mouse holds its last value; no strobe.
- Reset asserted mid-EMIT: all outputs return to reset values asynchronously; no partial packet.
- Only ps2_mouse[24], the toggle, changes parity per packet; consumers may use either the toggle or pkt_strobe.

Test Plan:
- Prime and single move: is_mouse=1, report_cnt 0→1 with dx=+5, dy=+3, INVERT_Y=1 → one packet: [15:8]=0x05, [23:16]=0xFD, status=0x28, toggle 0→1, pkt_strobe one cycle.
- Large delta split: one report with dx=+600 → packets X=255 (ovf=1), then X=255 (ovf=1), then X=90 (ovf=0), spaced exactly PKT_INTERVAL cycles apart, then no further strobes.
- Button only: left pressed with zero motion, cnt increments → status=0x09. A release report → status=0x08. Two packets, no extra packets afterwards.
- Counter wrap and jump: last_cnt=FFFF, report_cnt=0000 with dx=1 → accumulated once. Jump 0000→0005 with dx=2 → accumulated once (X total 3 if not yet emitted).
- Saturation: ACC_W=12, ten reports of dx=+1000 within one interval → acc_x=2047, sat_flag=1, then cleared on the first packet.
- Disable and reset: enable=0 with acc_x=40 → no packet, acc cleared, ps2_mouse unchanged. reset_n low mid-stream → ps2_mouse=0 and sat_flag=0 immediately. Re-prime does not accumulate the current report.
